// File: rtl/apb_slave_regfile_pkg.sv
// Shared definitions for the APB register-file completer: FSM encoding,
// bus widths, response codes and the latched-transfer record.
package apb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;
  localparam int IDX_W  = 4;
  localparam int CNT_W  = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic              err;
    logic              wr;
    logic [APB_DW-1:0] wdata;
  } xfer_t;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between a requester and the register-file completer.
interface apb_slave_regfile_if;

  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [apb_pkg::APB_AW-1:0] paddr;
  logic [apb_pkg::APB_DW-1:0] pwdata;
  logic [apb_pkg::APB_DW-1:0] prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);

endinterface

// File: rtl/apb_slave_regfile_addr_decode.sv
// Maps a byte address onto a register index and flags unmapped/misaligned access.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int               NUM_REGS  = 8,
  parameter logic [APB_AW-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic [APB_AW-1:0] paddr,
  output logic [IDX_W-1:0]  idx,
  output logic              err
);

  logic [APB_AW-1:0] offset_s;
  logic [APB_AW-1:0] word_s;

  always_comb begin
    offset_s = paddr - BASE_ADDR;
    word_s   = offset_s >> 2;
    idx      = word_s[IDX_W-1:0];
    err      = (paddr[1:0] != 2'b00) || (paddr < BASE_ADDR) ||
               (word_s >= 32'(NUM_REGS));
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with NUM_REGS read/write registers, programmable wait states,
// error responses and per-register write strobes towards peripheral logic.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int               NUM_REGS    = 8,
  parameter int               WAIT_STATES = 1,
  parameter logic [APB_AW-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [APB_DW-1:0] RESET_VAL   = 32'h0000_0000
) (
  input  logic                       pclk,
  input  logic                       preset,
  apb_slave_regfile_if.slave         apb,
  output logic [NUM_REGS*APB_DW-1:0] reg_q,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  xfer_t             xfer_q, xfer_d;
  logic [APB_DW-1:0] prdata_q, prdata_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [APB_DW-1:0] regs_q [NUM_REGS];
  logic [APB_DW-1:0] regs_d [NUM_REGS];

  logic [IDX_W-1:0]  dec_idx_s;
  logic              dec_err_s;
  logic              resp_s;
  logic              start_s;
  logic              commit_s;
  logic [APB_DW-1:0] rd_val_s;

  apb_addr_decode #(
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .paddr (apb.paddr),
    .idx   (dec_idx_s),
    .err   (dec_err_s)
  );

  // Next-state, wait counter, register writes and read-data capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    xfer_d     = xfer_q;
    prdata_d   = prdata_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    resp_s     = 1'b0;
    start_s    = 1'b0;
    commit_s   = 1'b0;
    rd_val_s   = 32'h0000_0000;

    case (state_q)
      ST_IDLE: begin
        if (apb.psel && !apb.penable) begin
          start_s = 1'b1;
        end else if (apb.psel && apb.penable) begin
          state_d    = ST_RESP;
          xfer_d.err = RESP_ERR;
          xfer_d.wr  = 1'b0;
          prdata_d   = 32'h0000_0000;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (!apb.psel) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          resp_s = 1'b1;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = (cnt_q == 4'd1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!apb.psel) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
          state_d = (cnt_q <= 4'd1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_RESP: begin
        resp_s = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (resp_s) begin
      commit_s = xfer_q.wr && !xfer_q.err;
      if (apb.psel && !apb.penable) begin
        start_s = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      commit_s = 1'b0;
    end

    for (int i = 0; i < NUM_REGS; i++) begin
      if (commit_s && (xfer_q.idx == IDX_W'(i))) begin
        regs_d[i]     = xfer_q.wdata;
        wr_pulse_d[i] = 1'b1;
      end else begin
        wr_pulse_d[i] = 1'b0;
      end
    end

    // Reading from regs_d forwards a write completing in the same cycle
    for (int i = 0; i < NUM_REGS; i++) begin
      if (dec_idx_s == IDX_W'(i)) begin
        rd_val_s = regs_d[i];
      end else begin
        rd_val_s = rd_val_s;
      end
    end

    if (start_s) begin
      state_d      = ST_SETUP;
      cnt_d        = CNT_W'(WAIT_STATES);
      xfer_d.idx   = dec_idx_s;
      xfer_d.err   = dec_err_s;
      xfer_d.wr    = apb.pwrite;
      xfer_d.wdata = apb.pwdata;
      prdata_d     = (!apb.pwrite && !dec_err_s) ? rd_val_s : 32'h0000_0000;
    end else begin
      prdata_d = prdata_d;
    end
  end

  // State and register array update with synchronous reset
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      xfer_q     <= '0;
      prdata_q   <= 32'h0000_0000;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      xfer_q     <= xfer_d;
      prdata_q   <= prdata_d;
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign apb.pready  = resp_s;
  assign apb.pslverr = resp_s ? xfer_q.err : RESP_OKAY;
  assign apb.prdata  = resp_s ? prdata_q : 32'h0000_0000;
  assign wr_pulse    = wr_pulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
    assign reg_q[APB_DW*g +: APB_DW] = regs_q[g];
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Random and directed APB traffic into three register files (1, 0 and 3 wait
// states) compared against an array model of the register contents.
module tb_apb_slave_regfile;

  logic clk = 1'b0;
  logic preset;
  always #5 clk = ~clk;

  logic        psel_a    [3];
  logic        penable_a [3];
  logic        pwrite_a  [3];
  logic [31:0] paddr_a   [3];
  logic [31:0] pwdata_a  [3];
  logic [31:0] prdata_a  [3];
  logic        pready_a  [3];
  logic        pslverr_a [3];
  logic [255:0] regq_a   [3];
  logic [7:0]  wrp_a     [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_slave_regfile_if bus ();
    assign bus.psel    = psel_a[g];
    assign bus.penable = penable_a[g];
    assign bus.pwrite  = pwrite_a[g];
    assign bus.paddr   = paddr_a[g];
    assign bus.pwdata  = pwdata_a[g];
    assign prdata_a[g]  = bus.prdata;
    assign pready_a[g]  = bus.pready;
    assign pslverr_a[g] = bus.pslverr;

    apb_slave_regfile #(
      .NUM_REGS    (8),
      .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
      .BASE_ADDR   (32'h0000_0000),
      .RESET_VAL   (32'h0000_0000)
    ) dut (
      .pclk     (clk),
      .preset   (preset),
      .apb      (bus),
      .reg_q    (regq_a[g]),
      .wr_pulse (wrp_a[g])
    );
  end

  int          ws [3] = '{1, 0, 3};
  logic [31:0] mem [3][8];
  int          n_chk = 0;
  int          n_bad = 0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] model_regq(input int d);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = mem[d][i];
    return r;
  endfunction

  task automatic bus_idle(input int d);
    psel_a[d] = 1'b0; penable_a[d] = 1'b0;
  endtask

  // Full transfer starting just after a rising edge; returns just after one.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    bit          err;
    bit          done;
    int          lat;
    logic [31:0] exp_rd;
    logic [7:0]  exp_pulse;
    logic [2:0]  widx;
    widx      = addr[4:2];
    err       = (addr[1:0] != 2'b00) || (addr >= 32'd32);
    exp_rd    = (wr || err) ? 32'h0 : mem[d][widx];
    exp_pulse = (wr && !err) ? (8'd1 << widx) : 8'd0;
    psel_a[d] = 1'b1; penable_a[d] = 1'b0; pwrite_a[d] = wr;
    paddr_a[d] = addr; pwdata_a[d] = data;
    @(posedge clk); #1 penable_a[d] = 1'b1;
    lat = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk); lat++;
      if (pready_a[d]) begin
        done = 1'b1;
        check_val("pslverr", pslverr_a[d], err);
        check_val("prdata", prdata_a[d], exp_rd);
      end else begin
        @(posedge clk); #1;
      end
    end
    check_val("pready_seen", done, 1);
    check_val("cycles", lat + 1, ws[d] + 2);
    @(posedge clk); #1 bus_idle(d);
    if (wr && !err) mem[d][widx] = data;
    check_val("wr_pulse", wrp_a[d], exp_pulse);
    check_val("reg_q", regq_a[d], model_regq(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    preset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      bus_idle(d); pwrite_a[d] = 1'b0; paddr_a[d] = 32'h0; pwdata_a[d] = 32'h0;
      for (int i = 0; i < 8; i++) mem[d][i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_val("rst_regq", regq_a[d], 256'h0);
      check_val("rst_pready", pready_a[d], 1'b0);
      check_val("rst_pslverr", pslverr_a[d], 1'b0);
      check_val("rst_prdata", prdata_a[d], 32'h0);
      check_val("rst_wrpulse", wrp_a[d], 8'h0);
    end
    @(posedge clk); #1 preset = 1'b0;

    // Directed: one wait state write/read
    xfer(0, 1'b1, 32'h04, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 32'h04, 32'h0);
    // Zero wait states, back-to-back
    xfer(1, 1'b1, 32'h00, 32'h0000_0055);
    xfer(1, 1'b0, 32'h00, 32'h0);
    // Error responses
    xfer(0, 1'b0, 32'h20, 32'h0);
    xfer(0, 1'b1, 32'h06, 32'h1234_5678);

    // Abort: psel drops during WAIT
    psel_a[2] = 1'b1; penable_a[2] = 1'b0; pwrite_a[2] = 1'b1;
    paddr_a[2] = 32'h08; pwdata_a[2] = 32'hCAFE_F00D;
    @(posedge clk); #1 penable_a[2] = 1'b1;
    @(negedge clk); check_val("abort_setup_pready", pready_a[2], 1'b0);
    @(posedge clk); #1;
    @(negedge clk); check_val("abort_wait_pready", pready_a[2], 1'b0);
    @(posedge clk); #1 bus_idle(2);
    @(negedge clk); check_val("abort_after_pready", pready_a[2], 1'b0);
    @(posedge clk); #1;
    check_val("abort_wrpulse", wrp_a[2], 8'h0);
    check_val("abort_regq", regq_a[2], model_regq(2));
    xfer(2, 1'b0, 32'h08, 32'h0);

    // Protocol violation: access phase without setup
    psel_a[0] = 1'b1; penable_a[0] = 1'b1; pwrite_a[0] = 1'b1;
    paddr_a[0] = 32'h04; pwdata_a[0] = 32'h0000_FFFF;
    @(negedge clk); check_val("proto_early_pready", pready_a[0], 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_val("proto_pready", pready_a[0], 1'b1);
    check_val("proto_pslverr", pslverr_a[0], 1'b1);
    check_val("proto_prdata", prdata_a[0], 32'h0);
    @(posedge clk); #1 bus_idle(0);
    check_val("proto_wrpulse", wrp_a[0], 8'h0);
    check_val("proto_regq", regq_a[0], model_regq(0));

    // Reset during WAIT of a write
    psel_a[2] = 1'b1; penable_a[2] = 1'b0; pwrite_a[2] = 1'b1;
    paddr_a[2] = 32'h0C; pwdata_a[2] = 32'h0000_00AA;
    @(posedge clk); #1 penable_a[2] = 1'b1;
    @(posedge clk); #1 preset = 1'b1;
    @(negedge clk); check_val("midrst_wait_pready", pready_a[2], 1'b0);
    @(posedge clk); #1 preset = 1'b0; bus_idle(2);
    for (int d = 0; d < 3; d++) for (int i = 0; i < 8; i++) mem[d][i] = 32'h0;
    @(negedge clk);
    check_val("midrst_pready", pready_a[2], 1'b0);
    check_val("midrst_reg3", regq_a[2][127:96], 32'h0);
    check_val("midrst_regq", regq_a[2], model_regq(2));
    check_val("midrst_regq0", regq_a[0], model_regq(0));
    @(posedge clk); #1;
    xfer(2, 1'b0, 32'h0C, 32'h0);
    xfer(2, 1'b1, 32'h1C, 32'h0BAD_F00D);

    // Randomized traffic across all three instances
    for (int n = 0; n < 60; n++) begin
      int          d;
      int          k;
      bit          wr;
      logic [31:0] addr;
      d  = int'($urandom_range(0, 2));
      wr = 1'($urandom_range(0, 1));
      k  = int'($urandom_range(0, 11));
      if (k < 9) addr = 32'(k * 4);
      else       addr = 32'($urandom_range(0, 35));
      xfer(d, wr, addr, $urandom);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
